comando_nivel_mais_menos: RTL and testbench

- Front-end that turns the operator's raise/lower buttons into the one-cycle `soma`/`sub`/`enp` command pulses consumed by the drone's limited 1..5 level counter.
- Synchronises and debounces both buttons, then emits exactly one command per accepted press.
- Optionally auto-repeats while a button is held.
- Suppresses commands that would push the level past its limits and flags them on `rejeitado`.

---
 rtl/comando_nivel_mais_menos.sv | 199 +++++++++++++++++++
 tb/tb_comando_nivel_mais_menos.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/comando_nivel_mais_menos.sv
// Raise/lower button front-end: synchronise, debounce and emit one-cycle soma/sub/enp commands with limit rejection.
// Optional auto-repeat while held is enabled by defining COMANDO_NIVEL_AUTO_REPEAT_EN.
module comando_nivel_mais_menos #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       botao_mais,
    input  logic       botao_menos,
    input  logic [2:0] nivel,
    output logic       soma,
    output logic       sub,
    output logic       enp,
    output logic       rejeitado,
    output logic [2:0] db_estado
);

    generate
        if (DEBOUNCE_CICLOS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_invalid
            $error("comando_nivel_mais_menos: counts must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        PULSO         = 3'd1,
        SEGURA        = 3'd2,
        REPETE        = 3'd3,
        ESPERA_SOLTAR = 3'd4
    } estado_t;

    localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);

    logic [1:0] botoes;
    logic [1:0] sync1;
    logic [1:0] sync2;

    assign botoes = {botao_mais, botao_menos};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clock or negedge clr) begin
                if (!clr) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= botoes[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync1[gi] = s1_reg;
            assign sync2[gi] = s2_reg;
        end
    endgenerate

    // sync1 is the value sync2 takes next edge, so a mismatch marks a change of the pair.
    logic [DW-1:0] db_cnt_reg;
    logic [1:0]    filt_reg;

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            db_cnt_reg <= '0;
            filt_reg   <= 2'b00;
        end else if (sync1 != sync2) begin
            db_cnt_reg <= '0;
        end else if (sync2 != filt_reg) begin
            if (db_cnt_reg >= DW'(DEBOUNCE_CICLOS - 1)) begin
                filt_reg   <= sync2;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + DW'(1);
            end
        end else begin
            db_cnt_reg <= '0;
        end
    end

    logic libera_mais;
    logic libera_menos;
    logic libera_dir;

    estado_t    estado_reg;
    logic       dir_mais_reg;
    logic [1:0] padrao;
    logic       soma_reg;
    logic       sub_reg;
    logic       enp_reg;
    logic       rej_reg;

    assign libera_mais  = (nivel != 3'd5);
    assign libera_menos = (nivel != 3'd1);
    assign libera_dir   = dir_mais_reg ? libera_mais : libera_menos;
    assign padrao       = dir_mais_reg ? 2'b10 : 2'b01;

`ifdef COMANDO_NIVEL_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt_reg;
`endif

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            estado_reg   <= OCIOSO;
            dir_mais_reg <= 1'b0;
            soma_reg     <= 1'b0;
            sub_reg      <= 1'b0;
            enp_reg      <= 1'b0;
            rej_reg      <= 1'b0;
`ifdef COMANDO_NIVEL_AUTO_REPEAT_EN
            rep_cnt_reg  <= '0;
`endif
        end else begin
            soma_reg <= 1'b0;
            sub_reg  <= 1'b0;
            enp_reg  <= 1'b0;
            rej_reg  <= 1'b0;
            case (estado_reg)
                OCIOSO: begin
                    // The command is registered on the edge entering PULSO, using nivel from that edge.
                    if (filt_reg == 2'b10) begin
                        estado_reg   <= PULSO;
                        dir_mais_reg <= 1'b1;
                        if (libera_mais) begin
                            soma_reg <= 1'b1;
                            enp_reg  <= 1'b1;
                        end else begin
                            rej_reg <= 1'b1;
                        end
                    end else if (filt_reg == 2'b01) begin
                        estado_reg   <= PULSO;
                        dir_mais_reg <= 1'b0;
                        if (libera_menos) begin
                            sub_reg <= 1'b1;
                            enp_reg <= 1'b1;
                        end else begin
                            rej_reg <= 1'b1;
                        end
                    end else if (filt_reg == 2'b11) begin
                        estado_reg <= ESPERA_SOLTAR;
                    end
                end
                PULSO: begin
                    estado_reg <= SEGURA;
`ifdef COMANDO_NIVEL_AUTO_REPEAT_EN
                    rep_cnt_reg <= '0;
`endif
                end
                SEGURA, REPETE: begin
                    if (filt_reg == 2'b00) begin
                        estado_reg <= OCIOSO;
                    end else if (filt_reg != padrao) begin
                        estado_reg <= ESPERA_SOLTAR;
                    end else begin
`ifdef COMANDO_NIVEL_AUTO_REPEAT_EN
                        if ((estado_reg == SEGURA && rep_cnt_reg >= RW'(REPEAT_DELAY - 1)) ||
                            (estado_reg == REPETE && rep_cnt_reg >= RW'(REPEAT_PERIOD - 1))) begin
                            estado_reg  <= REPETE;
                            rep_cnt_reg <= '0;
                            if (libera_dir) begin
                                soma_reg <= dir_mais_reg;
                                sub_reg  <= !dir_mais_reg;
                                enp_reg  <= 1'b1;
                            end else begin
                                rej_reg <= 1'b1;
                            end
                        end else begin
                            rep_cnt_reg <= rep_cnt_reg + RW'(1);
                        end
`else
                        estado_reg <= SEGURA;
`endif
                    end
                end
                ESPERA_SOLTAR: begin
                    if (filt_reg == 2'b00) begin
                        estado_reg <= OCIOSO;
                    end
                end
                default: estado_reg <= OCIOSO;
            endcase
        end
    end

`ifndef COMANDO_NIVEL_AUTO_REPEAT_EN
    logic unused_ok;
    assign unused_ok = libera_dir;
`endif

    assign soma      = soma_reg;
    assign sub       = sub_reg;
    assign enp       = enp_reg;
    assign rejeitado = rej_reg;
    assign db_estado = estado_reg;

endmodule

// File: tb/tb_comando_nivel_mais_menos.sv
// Directed bench for comando_nivel_mais_menos with DEBOUNCE_CICLOS=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_comando_nivel_mais_menos;

    logic       clock = 1'b0;
    logic       clr = 1'b0;
    logic       botao_mais = 1'b0;
    logic       botao_menos = 1'b0;
    logic [2:0] nivel = 3'd2;
    logic       soma;
    logic       sub;
    logic       enp;
    logic       rejeitado;
    logic [2:0] db_estado;

    comando_nivel_mais_menos #(
        .DEBOUNCE_CICLOS(4),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(3)
    ) dut (
        .clock(clock),
        .clr(clr),
        .botao_mais(botao_mais),
        .botao_menos(botao_menos),
        .nivel(nivel),
        .soma(soma),
        .sub(sub),
        .enp(enp),
        .rejeitado(rejeitado),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    int edge_no, cnt_soma, cnt_sub, cnt_enp, cnt_rej, first_soma, first_sub, first_rej, viol;
    int pulse_edges[$];

`ifdef COMANDO_NIVEL_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic clear_obs();
        edge_no = 0; cnt_soma = 0; cnt_sub = 0; cnt_enp = 0; cnt_rej = 0;
        first_soma = 0; first_sub = 0; first_rej = 0; viol = 0;
        pulse_edges.delete();
    endtask

    // Advance n rising edges, sampling 1 time unit after each one.
    task automatic run_edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            edge_no++;
            if (soma) begin cnt_soma++; if (first_soma == 0) first_soma = edge_no; end
            if (sub) begin cnt_sub++; if (first_sub == 0) first_sub = edge_no; end
            if (rejeitado) begin cnt_rej++; if (first_rej == 0) first_rej = edge_no; end
            if (enp) begin cnt_enp++; pulse_edges.push_back(edge_no); end
            if ((soma && sub) || (enp != (soma ^ sub)) || (rejeitado && enp)) viol++;
        end
    endtask

    task automatic release_idle(input string tag);
        @(negedge clock);
        botao_mais = 1'b0;
        botao_menos = 1'b0;
        run_edges(12);
        check(tag, int'(db_estado), 0);
        check({tag, "_viol"}, viol, 0);
    endtask

    task automatic press_and_check(input string tag, input logic m, input logic [2:0] lv,
                                   input int exp_first_cmd, input int exp_first_rej);
        nivel = lv;
        clear_obs();
        @(negedge clock);
        if (m) botao_mais = 1'b1; else botao_menos = 1'b1;
        run_edges(12);
        check({tag, "_cmd_edge"}, m ? first_soma : first_sub, exp_first_cmd);
        check({tag, "_other_cmd"}, m ? cnt_sub : cnt_soma, 0);
        check({tag, "_rej_edge"}, first_rej, exp_first_rej);
        check({tag, "_enp_cnt"}, cnt_enp, (exp_first_cmd != 0) ? 1 : 0);
        release_idle({tag, "_idle"});
    endtask

    initial begin
        clear_obs();
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_soma", int'(soma), 0);
        check("rst_sub", int'(sub), 0);
        check("rst_enp", int'(enp), 0);
        check("rst_rej", int'(rejeitado), 0);
        check("rst_estado", int'(db_estado), 0);
        @(negedge clock);
        clr = 1'b1;
        run_edges(10);
        check("idle_enp", cnt_enp, 0);

        // Single press, nivel=2, hold 30 cycles
        nivel = 3'd2;
        clear_obs();
        @(negedge clock);
        botao_mais = 1'b1;
        run_edges(30);
        check("single_first_soma", first_soma, 7);
        check("single_soma_cnt", cnt_soma, REP ? 6 : 1);
        check("single_enp_cnt", cnt_enp, REP ? 6 : 1);
        check("single_sub_cnt", cnt_sub, 0);
        check("single_held_estado", int'(db_estado), REP ? 3 : 2);
        clear_obs();
        @(negedge clock);
        botao_mais = 1'b0;
        run_edges(6);
        check("single_rel6_estado", int'(db_estado), REP ? 3 : 2);
        run_edges(1);
        check("single_rel7_estado", int'(db_estado), 0);
        check("single_rel_enp", cnt_enp, REP ? 2 : 0);
        check("single_viol", viol, 0);

        // Bounce on botao_menos, nivel=3
        nivel = 3'd3;
        clear_obs();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            botao_menos = (i % 3 == 0);
            run_edges(1);
        end
        check("bounce_enp_cnt", cnt_enp, 0);
        check("bounce_estado", int'(db_estado), 0);
        clear_obs();
        @(negedge clock);
        botao_menos = 1'b1;
        run_edges(12);
        check("bounce_first_sub", first_sub, 7);
        check("bounce_sub_cnt", cnt_sub, 1);
        release_idle("bounce_idle");

        // Limits and non-limit nivel values
        press_and_check("lim_mais5", 1'b1, 3'd5, 0, 7);
        press_and_check("lim_menos1", 1'b0, 3'd1, 0, 7);
        press_and_check("mais_nivel6", 1'b1, 3'd6, 7, 0);
        press_and_check("menos_nivel0", 1'b0, 3'd0, 7, 0);
        press_and_check("mais_nivel4", 1'b1, 3'd4, 7, 0);

        // Both buttons together
        nivel = 3'd2;
        clear_obs();
        @(negedge clock);
        botao_mais = 1'b1;
        botao_menos = 1'b1;
        run_edges(20);
        check("both_held_estado", int'(db_estado), 4);
        @(negedge clock);
        botao_mais = 1'b0;
        run_edges(10);
        check("both_one_estado", int'(db_estado), 4);
        @(negedge clock);
        botao_menos = 1'b0;
        run_edges(6);
        check("both_rel6_estado", int'(db_estado), 4);
        run_edges(1);
        check("both_rel7_estado", int'(db_estado), 0);
        check("both_enp_cnt", cnt_enp, 0);
        check("both_rej_cnt", cnt_rej, 0);

        // Auto-repeat window: hold mais 39 cycles then release
        nivel = 3'd2;
        clear_obs();
        @(negedge clock);
        botao_mais = 1'b1;
        run_edges(39);
        @(negedge clock);
        botao_mais = 1'b0;
        run_edges(10);
        check("rep_enp_cnt", cnt_enp, REP ? 11 : 1);
        check("rep_edge0", (pulse_edges.size() > 0) ? pulse_edges[0] : -1, 7);
        if (REP) begin
            check("rep_edge1", (pulse_edges.size() > 1) ? pulse_edges[1] : -1, 16);
            check("rep_edge2", (pulse_edges.size() > 2) ? pulse_edges[2] : -1, 19);
        end
        check("rep_last_edge", (pulse_edges.size() > 0) ? pulse_edges[pulse_edges.size() - 1] : -1,
              REP ? 43 : 7);
        check("rep_end_estado", int'(db_estado), 0);
        check("rep_viol", viol, 0);

        // Reset asserted during the enp cycle
        nivel = 3'd2;
        clear_obs();
        @(negedge clock);
        botao_mais = 1'b1;
        run_edges(7);
        check("mid_enp_before", int'(enp), 1);
        #1;
        clr = 1'b0;
        #1;
        check("mid_soma", int'(soma), 0);
        check("mid_enp", int'(enp), 0);
        check("mid_estado", int'(db_estado), 0);
        @(negedge clock);
        clr = 1'b1;
        clear_obs();
        run_edges(12);
        check("mid_fresh_soma_edge", first_soma, 7);
        check("mid_fresh_soma_cnt", cnt_soma, 1);
        release_idle("mid_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
